// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words and writes them to IMEM.
// Optional trailing-word XOR checksum is enabled with `define IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start; byte_ready low
// COLLECT | accepting the 4 bytes of the current instruction word
// WRITE   | single-cycle mem_we strobe for the assembled word
// CHECK   | accepting the 4-byte checksum word (checksum build only)
// DONE    | one-cycle done pulse, then back to IDLE
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        checksum_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] wc_lat;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic        xfer;
  logic        last_word;
  logic [31:0] word_full;
  logic [AW-1:0] slot;
  logic [31:0] slot_addr;

  assign xfer      = byte_valid && byte_ready;
  assign last_word = (word_idx + 16'd1) == wc_lat;
  // The byte arriving now is the top byte; earlier bytes already sit in partial.
  assign word_full = {byte_in, partial};

  generate
    if (DEPTH_WORDS > 1) begin : g_slot
      assign slot = word_idx[AW-1:0];
    end else begin : g_slot_one
      assign slot = '0;
    end
  endgenerate

  assign slot_addr = BASE_ADDR + (32'(slot) << 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_acc;
`else
  assign checksum_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wc_lat       <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      partial      <= '0;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_address  <= BASE_ADDR;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_acc     <= '0;
      checksum_err <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wc_lat   <= word_count;
            word_idx <= '0;
            byte_cnt <= '0;
            partial  <= '0;
            busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc     <= '0;
            checksum_err <= 1'b0;
`endif
            if (word_count == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= COLLECT;
              byte_ready <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (xfer) begin
            partial  <= {byte_in, partial[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state       <= WRITE;
              byte_ready  <= 1'b0;
              mem_we      <= 1'b1;
              mem_address <= slot_addr;
              mem_wdata   <= word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum_acc    <= csum_acc ^ word_full;
`endif
            end
          end
        end

        WRITE: begin
          word_idx <= word_idx + 16'd1;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CHECK;
            byte_ready <= 1'b1;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            state      <= COLLECT;
            byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            partial  <= {byte_in, partial[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state        <= DONE;
              byte_ready   <= 1'b0;
              done         <= 1'b1;
              checksum_err <= (word_full != csum_acc);
            end
          end
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
